// File: rtl/cell_comm_link_monitor_if.sv
// Bundles the link-monitor event inputs, control strobes and readout bus.
// master: the side that drives link events and reads back; slave: the monitor.
interface cell_comm_link_monitor_if #(
    parameter int NCHAN      = 2,
    parameter int CHW        = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NCHAN-1:0]      chanUp;
    logic [NCHAN-1:0]      rxTvalid;
    logic [NCHAN-1:0]      rxTlast;
    logic [NCHAN-1:0]      rxCRCvalid;
    logic [NCHAN-1:0]      rxCRCpass;
    logic                  snapStrobe;
    logic                  clrStrobe;
    logic [CHW-1:0]        rdChan;
    logic [1:0]            rdReg;
    logic [DATA_WIDTH-1:0] rdData;
    logic [NCHAN-1:0]      staleFlags;

    modport master (
        output chanUp, rxTvalid, rxTlast, rxCRCvalid, rxCRCpass,
        output snapStrobe, clrStrobe, rdChan, rdReg,
        input  rdData, staleFlags
    );

    modport slave (
        input  chanUp, rxTvalid, rxTlast, rxCRCvalid, rxCRCpass,
        input  snapStrobe, clrStrobe, rdChan, rdReg,
        output rdData, staleFlags
    );
endinterface

// File: rtl/cell_comm_link_monitor.sv
// N-channel Aurora link statistics/health monitor: saturating CRC-fault,
// frame and up-loss counters, global snapshot shadows, stale-link watchdog
// and a registered shadow readout. All inputs are already on sysClk.
// Optional fault interrupt: define CELL_COMM_LINK_MONITOR_IRQ_EN.
module cell_comm_link_monitor #(
    parameter int NCHAN          = 2,
    parameter int COUNT_WIDTH    = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CHW            = 4
) (
    input  logic                     sysClk,
    input  logic                     sysReset_n,
    cell_comm_link_monitor_if.slave  bus
`ifdef CELL_COMM_LINK_MONITOR_IRQ_EN
    ,
    output logic                     irq
`endif
);
    // Reject illegal configurations at elaboration time
    if (NCHAN < 1 || NCHAN > 16) begin : g_bad_nchan
        $error("NCHAN must be 1..16");
    end
    if (COUNT_WIDTH < 1 || COUNT_WIDTH > DATA_WIDTH) begin : g_bad_cw
        $error("COUNT_WIDTH must be 1..DATA_WIDTH");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_to
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if ((1 << CHW) < NCHAN) begin : g_bad_chw
        $error("2**CHW must cover NCHAN");
    end

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef logic [COUNT_WIDTH-1:0] cnt_t;
    typedef logic [WDW-1:0]         wd_t;
    typedef struct packed {
        cnt_t crc;
        cnt_t frm;
        cnt_t ul;
    } cnt_set_t;

    localparam wd_t WD_MAX = wd_t'(TIMEOUT_CYCLES);

    cnt_set_t [NCHAN-1:0]  live_q, live_d;
    cnt_set_t [NCHAN-1:0]  shadow_q, shadow_d;
    wd_t      [NCHAN-1:0]  wd_q, wd_d;
    logic     [NCHAN-1:0]  stale_q, stale_d;
    logic     [NCHAN-1:0]  prev_up_q;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic     [NCHAN-1:0]  sticky_vec;

    logic [NCHAN-1:0] crc_ev, frame_end, up_loss;
    assign crc_ev    = bus.rxCRCvalid & ~bus.rxCRCpass;
    assign frame_end = bus.rxTvalid & bus.rxTlast;
    assign up_loss   = prev_up_q & ~bus.chanUp;

    function automatic cnt_t sat_inc(input cnt_t v, input logic ev);
        return (ev && v != '1) ? cnt_t'(v + 1'b1) : v;
    endfunction

    // Counter, shadow and watchdog next-state; clear beats increment, snapshot sees pre-edge values
    always_comb begin
        live_d   = live_q;
        shadow_d = shadow_q;
        wd_d     = wd_q;
        stale_d  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (bus.snapStrobe) shadow_d[i] = live_q[i];
            if (bus.clrStrobe) begin
                live_d[i] = '0;
            end else begin
                live_d[i].crc = sat_inc(live_q[i].crc, crc_ev[i]);
                live_d[i].frm = sat_inc(live_q[i].frm, frame_end[i]);
                live_d[i].ul  = sat_inc(live_q[i].ul,  up_loss[i]);
            end
            if (!bus.chanUp[i] || frame_end[i]) wd_d[i] = '0;
            else if (wd_q[i] != WD_MAX)         wd_d[i] = wd_t'(wd_q[i] + 1'b1);
            stale_d[i] = (wd_d[i] == WD_MAX);
        end
    end

    // Readout mux: shadows for counters, live status for reg 3, zero for absent channels
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (bus.rdChan == CHW'(i)) begin
                case (bus.rdReg)
                    2'd0:    rd_data_d = DATA_WIDTH'(shadow_q[i].crc);
                    2'd1:    rd_data_d = DATA_WIDTH'(shadow_q[i].frm);
                    2'd2:    rd_data_d = DATA_WIDTH'(shadow_q[i].ul);
                    default: rd_data_d = DATA_WIDTH'({sticky_vec[i], stale_q[i], bus.chanUp[i]});
                endcase
            end
        end
    end

    // Main state registers
    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            live_q    <= '0;
            shadow_q  <= '0;
            wd_q      <= '0;
            stale_q   <= '0;
            prev_up_q <= '0;
            rd_data_q <= '0;
        end else begin
            live_q    <= live_d;
            shadow_q  <= shadow_d;
            wd_q      <= wd_d;
            stale_q   <= stale_d;
            prev_up_q <= bus.chanUp;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef CELL_COMM_LINK_MONITOR_IRQ_EN
    logic [NCHAN-1:0] sticky_q, sticky_d;
    logic             irq_q, irq_d;

    // Sticky fault bits: a new fault overrides a same-cycle clear; irq lags sticky by one cycle
    always_comb begin
        sticky_d = (sticky_q & ~{NCHAN{bus.clrStrobe}}) | crc_ev | up_loss;
        irq_d    = |sticky_q;
    end

    // Fault interrupt registers
    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            irq_q    <= irq_d;
        end
    end

    assign sticky_vec = sticky_q;
    assign irq        = irq_q;
`else
    assign sticky_vec = '0;
`endif

    assign bus.rdData     = rd_data_q;
    assign bus.staleFlags = stale_q;
endmodule

// File: tb/tb_cell_comm_link_monitor.sv
// Self-checking bench for cell_comm_link_monitor: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a counting model of the link monitor.
module tb_cell_comm_link_monitor;
    localparam int NCHAN = 3;
    localparam int CW    = 4;
    localparam int DW    = 32;
    localparam int TO    = 10;
    localparam int CHW   = 2;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef CELL_COMM_LINK_MONITOR_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
    logic irq;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic sysClk = 1'b0;
    logic sysReset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    cell_comm_link_monitor_if #(.NCHAN(NCHAN), .CHW(CHW), .DATA_WIDTH(DW)) bus ();

    cell_comm_link_monitor #(
        .NCHAN(NCHAN), .COUNT_WIDTH(CW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CHW(CHW)
    ) dut (
        .sysClk(sysClk),
        .sysReset_n(sysReset_n),
        .bus(bus)
`ifdef CELL_COMM_LINK_MONITOR_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    initial forever #5 sysClk = ~sysClk;

    // ---------------- reference model ----------------
    int               m_crc[NCHAN], m_frm[NCHAN], m_ul[NCHAN];
    int               s_crc[NCHAN], s_frm[NCHAN], s_ul[NCHAN];
    int               m_wd[NCHAN];
    logic [NCHAN-1:0] m_prev, m_stale, m_sticky;
    int               m_rd;
    logic             m_irq;
    bit               m_valid = 1'b0;

    function automatic int bump(input int v, input bit ev);
        return (ev && v < CMAX) ? v + 1 : v;
    endfunction

    function automatic int model_read(input int ch, input int r);
        if (ch >= NCHAN) return 0;
        case (r)
            0:       return s_crc[ch];
            1:       return s_frm[ch];
            2:       return s_ul[ch];
            default: return int'(bus.chanUp[ch]) + 2 * int'(m_stale[ch])
                            + (HAS_IRQ ? 4 * int'(m_sticky[ch]) : 0);
        endcase
    endfunction

    task automatic model_step();
        bit ce, fe, ul;
        if (!sysReset_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                m_crc[i] = 0; m_frm[i] = 0; m_ul[i] = 0;
                s_crc[i] = 0; s_frm[i] = 0; s_ul[i] = 0; m_wd[i] = 0;
            end
            m_prev = '0; m_stale = '0; m_sticky = '0; m_rd = 0; m_irq = 1'b0;
        end else begin
            m_rd  = model_read(int'(bus.rdChan), int'(bus.rdReg));
            m_irq = (m_sticky != '0);
            for (int i = 0; i < NCHAN; i++) begin
                ce = bus.rxCRCvalid[i] && !bus.rxCRCpass[i];
                fe = bus.rxTvalid[i] && bus.rxTlast[i];
                ul = m_prev[i] && !bus.chanUp[i];
                if (bus.snapStrobe) begin
                    s_crc[i] = m_crc[i]; s_frm[i] = m_frm[i]; s_ul[i] = m_ul[i];
                end
                if (bus.clrStrobe) begin
                    m_crc[i] = 0; m_frm[i] = 0; m_ul[i] = 0;
                end else begin
                    m_crc[i] = bump(m_crc[i], ce);
                    m_frm[i] = bump(m_frm[i], fe);
                    m_ul[i]  = bump(m_ul[i], ul);
                end
                m_sticky[i] = (m_sticky[i] && !bus.clrStrobe) || ce || ul;
                m_prev[i]   = bus.chanUp[i];
                m_wd[i]     = (!bus.chanUp[i] || fe) ? 0 : ((m_wd[i] < TO) ? m_wd[i] + 1 : TO);
                m_stale[i]  = (m_wd[i] == TO);
            end
        end
        m_valid = 1'b1;
    endtask

    initial forever begin
        @(posedge sysClk);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model
    initial forever begin
        @(negedge sysClk);
        if (m_valid) begin
            check("rdData", bus.rdData, 32'(m_rd));
            check("staleFlags", 32'(bus.staleFlags), 32'(m_stale));
`ifdef CELL_COMM_LINK_MONITOR_IRQ_EN
            check("irq", 32'(irq), 32'(m_irq));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic idle();
        bus.rxTvalid = '0; bus.rxTlast = '0; bus.rxCRCvalid = '0; bus.rxCRCpass = '0;
        bus.snapStrobe = 1'b0; bus.clrStrobe = 1'b0;
    endtask

    task automatic snap();
        bus.snapStrobe = 1'b1; tick(); bus.snapStrobe = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, input int exp, input string nm);
        bus.rdChan = CHW'(ch); bus.rdReg = 2'(r);
        tick();
        check(nm, bus.rdData, 32'(exp));
    endtask

    task automatic pulse_crc(input int ch, input bit pass);
        bus.rxCRCvalid[ch] = 1'b1; bus.rxCRCpass[ch] = pass; tick();
        bus.rxCRCvalid[ch] = 1'b0; bus.rxCRCpass[ch] = 1'b0; tick();
    endtask

    task automatic pulse_frame(input int ch);
        bus.rxTvalid[ch] = 1'b1; bus.rxTlast[ch] = 1'b1; tick();
        bus.rxTvalid[ch] = 1'b0; bus.rxTlast[ch] = 1'b0; tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle();
        bus.chanUp = '0; bus.rdChan = '0; bus.rdReg = '0;

        // Reset with junk on the inputs; reset must win
        sysReset_n = 1'b0;
        repeat (3) begin
            bus.rxTvalid = NCHAN'($urandom); bus.rxTlast = NCHAN'($urandom);
            bus.rxCRCvalid = NCHAN'($urandom); bus.chanUp = NCHAN'($urandom);
            bus.snapStrobe = 1'b1;
            tick();
        end
        idle(); bus.chanUp = '0; tick();
        sysReset_n = 1'b1;
        check("reset_stale", 32'(bus.staleFlags), 0);
        check("reset_rdData", bus.rdData, 0);

        // First rise after reset is not an up-loss
        bus.chanUp[0] = 1'b1;
        repeat (3) tick();
        snap();
        rd(0, 2, 0, "uploss_ch0_after_reset");
        rd(3, 0, 0, "oob_channel");
        rd(0, 3, 1, "status_ch0_up");

        // Channel 1: 5 CRC fails, 3 passes, 7 frame ends, plus a non-last beat
        for (int k = 0; k < 5; k++) pulse_crc(1, 1'b0);
        for (int k = 0; k < 3; k++) pulse_crc(1, 1'b1);
        for (int k = 0; k < 7; k++) pulse_frame(1);
        bus.rxTvalid[1] = 1'b1; tick(); bus.rxTvalid[1] = 1'b0;
        snap();
        rd(1, 0, 5, "crc_ch1");
        rd(1, 1, 7, "frames_ch1");
        rd(0, 0, 0, "crc_ch0");
        rd(2, 1, 0, "frames_ch2");

        // Saturation at 4 bits
        bus.rxCRCvalid[2] = 1'b1;
        repeat (20) tick();
        bus.rxCRCvalid[2] = 1'b0;
        snap();
        rd(2, 0, 15, "crc_ch2_saturated");

        // Snapshot + clear + frame end in one cycle with frames=9
        pulse_frame(1); pulse_frame(1);
        bus.snapStrobe = 1'b1; bus.clrStrobe = 1'b1;
        bus.rxTvalid[1] = 1'b1; bus.rxTlast[1] = 1'b1;
        tick();
        idle();
        rd(1, 1, 9, "snapclr_shadow_frames");
        rd(2, 0, 15, "snapclr_shadow_crc2");
        snap();
        rd(1, 1, 0, "after_clear_frames");
        rd(2, 0, 0, "after_clear_crc2");

        // Watchdog on channel 2
        bus.chanUp[2] = 1'b1;
        repeat (9) tick();
        check("wd_cycle9", 32'(bus.staleFlags[2]), 0);
        tick();
        check("wd_cycle10", 32'(bus.staleFlags[2]), 1);
        bus.rxTvalid[2] = 1'b1; bus.rxTlast[2] = 1'b1; tick();
        idle();
        check("wd_frame_clears", 32'(bus.staleFlags[2]), 0);
        tick();
        bus.chanUp[2] = 1'b0; tick();
        check("wd_down_clears", 32'(bus.staleFlags[2]), 0);
        snap();
        rd(2, 2, 1, "uploss_ch2");

        // Mid-operation reset discards shadows
        bus.chanUp = '0;
        sysReset_n = 1'b0; tick(); sysReset_n = 1'b1;
        rd(2, 2, 0, "reset_clears_shadow");

`ifdef CELL_COMM_LINK_MONITOR_IRQ_EN
        bus.rxCRCvalid[0] = 1'b1; tick(); idle();
        check("irq_after_1", 32'(irq), 0);
        tick();
        check("irq_after_2", 32'(irq), 1);
        bus.clrStrobe = 1'b1; tick(); idle(); tick();
        check("irq_cleared", 32'(irq), 0);
        bus.rxCRCvalid[0] = 1'b1; tick(); idle(); tick();
        check("irq_refault", 32'(irq), 1);
        bus.clrStrobe = 1'b1; bus.rxCRCvalid[0] = 1'b1; tick(); idle(); tick(); tick();
        check("irq_clr_and_fault", 32'(irq), 1);
        rd(0, 3, 4, "status_sticky");
`endif

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            sysReset_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < NCHAN; i++)
                if ($urandom_range(0, 39) == 0) bus.chanUp[i] = ~bus.chanUp[i];
            bus.rxTvalid   = NCHAN'($urandom);
            for (int i = 0; i < NCHAN; i++) bus.rxTlast[i] = ($urandom_range(0, 15) == 0);
            bus.rxCRCvalid = NCHAN'($urandom);
            bus.rxCRCpass  = NCHAN'($urandom);
            bus.snapStrobe = ($urandom_range(0, 15) == 0);
            bus.clrStrobe  = ($urandom_range(0, 24) == 0);
            bus.rdChan     = CHW'($urandom);
            bus.rdReg      = 2'($urandom);
            tick();
        end
        idle();
        sysReset_n = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cell_comm_link_monitor.md
Name: cell_comm_link_monitor

Overview:
- N-channel statistics and health monitor for cell-communication Aurora links. Successor to the fixed two-link CRC fault counters: width and channel count are parametrised.
- Per channel it counts CRC faults, received frames and channel-up losses, and runs a stale-link watchdog.
- A global snapshot latches every channel's counters at the same instant. Software reads the shadows through a registered channel/register select.
- Sits after the per-link clock-domain crossings, so every input is already synchronous to sysClk.

Parameters:
- NCHAN, 2, number of monitored links (1..16).
- COUNT_WIDTH, 32, width of each counter (1..DATA_WIDTH).
- DATA_WIDTH, 32, width of the readout bus.
- TIMEOUT_CYCLES, 1000, sysClk cycles without a frame end before a link that is up is flagged stale (minimum 2).
- CHW, 4, width of rdChan (2^CHW must be at least NCHAN).

Ports:
- sysClk  in  1  single clock for all logic.
- sysReset_n  in  1  synchronous reset, active-low.
- chanUp  in  NCHAN  per-link channel-up.
- rxTvalid  in  NCHAN  per-link AXIS receive valid.
- rxTlast  in  NCHAN  per-link AXIS receive last.
- rxCRCvalid  in  NCHAN  per-link CRC result valid.
- rxCRCpass  in  NCHAN  per-link CRC pass, qualified by rxCRCvalid.
- snapStrobe  in  1  one-cycle pulse: copy live counters to shadows.
- clrStrobe  in  1  one-cycle pulse: zero all live counters.
- rdChan  in  CHW  readout channel select.
- rdReg  in  2  readout register select: 0 CRC faults, 1 frames, 2 up-losses, 3 status.
- rdData  out  DATA_WIDTH  registered readout data.
- staleFlags  out  NCHAN  per-link stale indication.
- irq  out  1  fault interrupt; exists only with the optional feature.

Behaviour:
- Reset (sysReset_n low at a sysClk edge) clears:
  - all live counters, shadows and watchdog counters;
  - prevUp, staleFlags and rdData;
  - irq and the sticky fault bits.
- Reset has priority over every other input. A reset asserted mid-operation discards all in-flight state.
- Live counters, per channel, each saturating at all ones with no wrap:
  - crcFaults increments on a cycle with rxCRCvalid=1 and rxCRCpass=0.
  - frames increments on a cycle with rxTvalid=1 and rxTlast=1.
  - upLoss increments on a cycle with prevUp=1 and chanUp=0. prevUp is registered chanUp and is 0 at reset, so the first rise after reset does not count.
- Events on different counters in the same cycle each apply. At most one increment per counter per cycle.
- clrStrobe: every live counter is 0 on the next cycle. A clear wins over a simultaneous increment; that event is lost.
- snapStrobe: the shadows take the live values from before that edge's updates. With snapStrobe and clrStrobe together, the shadows get the pre-clear values (read-and-clear semantics). A simultaneous increment is included in neither the snapshot nor the cleared counter.
- Watchdog, per channel:
  - wdCnt is 0 while chanUp=0 or on a frame end. Otherwise it increments, saturating at TIMEOUT_CYCLES.
  - staleFlags[i] goes to 1 on the cycle wdCnt reaches TIMEOUT_CYCLES.
  - staleFlags[i] returns to 0 on the cycle after a frame end or chanUp=0.
  - clrStrobe does not affect the watchdog.
- Readout:
  - rdData is valid one cycle after rdChan/rdReg are presented and always comes from the shadows, never the live counters.
  - Counters are zero-extended to DATA_WIDTH.
  - rdReg=3 returns live status: bit0 chanUp, bit1 staleFlags, bit2 sticky fault (0 if the feature is absent), other bits 0.
  - rdChan at or above NCHAN returns 0.
- Parameter checks: illegal parameter combinations stop elaboration via a generate-time error.

Optional Feature:
- Macro: CELL_COMM_LINK_MONITOR_IRQ_EN.
- With the macro defined:
  - A per-channel sticky fault bit is set by any CRC-fault event or upLoss event.
  - The sticky bits are cleared by clrStrobe; a set and a clear in the same cycle leaves the bit set.
  - irq is the registered OR of the sticky bits, one cycle after the sticky bits update.
- Without the macro: the irq port and sticky logic are absent, and status bit2 reads 0.

Test Plan:
- Reset behaviour: reset, then drive chanUp=1 on channel 0 -> upLoss reads 0; all rdData reads are 0; staleFlags=0.
- CRC and frame counting: on channel 1, 5 CRC-fail pulses, 3 CRC-pass pulses and 7 frame ends, then snapStrobe and read -> crcFaults=5, frames=7, other channels 0; rdData valid exactly 1 cycle after select.
- Saturation: COUNT_WIDTH=4, drive 20 CRC faults -> reads 15 and does not wrap.
- Snapshot with clear and increment: snapStrobe, clrStrobe and a frame end in the same cycle with frames=9 -> shadow=9, live=0; next snapshot reads 0.
- Watchdog timing: TIMEOUT_CYCLES=10, chanUp=1, no frames -> stale=1 exactly at cycle 10; one frame end clears it the next cycle; chanUp toggled 1->0 gives upLoss=1 and stale=0.
- IRQ (macro defined): one CRC fault -> irq=1 after 2 cycles; clrStrobe -> irq=0; clear and fault in the same cycle -> irq stays 1.
